// File: rtl/jtcontra_pkg.sv
// Shared types for the Contra ROM arbiter: FSM state encoding
// and grant identifiers for the two ROM requesters.
package jtcontra_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic GNT_MAIN = 1'b0;
  localparam logic GNT_SND  = 1'b1;

endpackage

// File: rtl/jtcontra_rom_slot.sv
// One-entry tag/data cache for a single ROM requester.
// Ports: cs/addr lookup -> ok/data; fill/fill_tag/fill_data write.
module jtcontra_rom_slot
  import jtcontra_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_tag,
  input  logic [7:0]    fill_data,
  output logic [7:0]    data,
  output logic          ok
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [7:0]    data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign ok   = cs & valid_q & (addr == tag_q);
  assign data = data_q;

endmodule

// File: rtl/jtcontra_rom_arb.sv
// Shares one SDRAM read port between main and sound CPU ROMs.
// Ports: main_*/snd_* requesters, sdram_* req/ack/dst handshake.
module jtcontra_rom_arb
  import jtcontra_pkg::*;
#(
  parameter int                MAIN_AW    = 17,
  parameter int                SND_AW     = 15,
  parameter int                SDR_AW     = 22,
  parameter logic [SDR_AW-1:0] SND_OFFSET = 22'h20000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic               snd_cs,
  input  logic [SND_AW-1:0]  snd_addr,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  output logic               sdram_req,
  output logic [SDR_AW-1:0]  sdram_addr,
  input  logic               sdram_ack,
  input  logic               sdram_dst,
  input  logic [7:0]         sdram_data
);

  localparam int LW = (MAIN_AW > SND_AW) ? MAIN_AW : SND_AW;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              req_q, req_d;
  logic [SDR_AW-1:0] addr_q, addr_d;
  logic [LW-1:0]     lat_q, lat_d;

  logic main_miss, snd_miss, fill;
  logic main_fill, snd_fill;

  assign main_miss = main_cs & ~main_ok;
  assign snd_miss  = snd_cs & ~snd_ok;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    req_d   = req_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    fill    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (main_miss | snd_miss) begin
          // tie goes to whoever was not served last
          if (main_miss & snd_miss) gnt_d = ~last_q;
          else if (main_miss)       gnt_d = GNT_MAIN;
          else                      gnt_d = GNT_SND;
          if (gnt_d == GNT_MAIN) begin
            lat_d  = LW'(main_addr);
            addr_d = SDR_AW'(main_addr);
          end else begin
            lat_d  = LW'(snd_addr);
            addr_d = SND_OFFSET + SDR_AW'(snd_addr);
          end
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_dst) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_dst) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (fill) last_d = gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_MAIN;
      last_q  <= GNT_SND;
      req_q   <= 1'b0;
      addr_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
    end
  end

  assign main_fill  = fill & (gnt_q == GNT_MAIN);
  assign snd_fill   = fill & (gnt_q == GNT_SND);
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  jtcontra_rom_slot #(.AW(MAIN_AW)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (main_cs),
    .addr      (main_addr),
    .fill      (main_fill),
    .fill_tag  (lat_q[MAIN_AW-1:0]),
    .fill_data (sdram_data),
    .data      (main_data),
    .ok        (main_ok)
  );

  jtcontra_rom_slot #(.AW(SND_AW)) u_snd (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (snd_cs),
    .addr      (snd_addr),
    .fill      (snd_fill),
    .fill_tag  (lat_q[SND_AW-1:0]),
    .fill_data (sdram_data),
    .data      (snd_data),
    .ok        (snd_ok)
  );

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// Self-checking bench for jtcontra_rom_arb: directed scenarios
// plus a randomized run against a cache/arbitration model.
module tb_jtcontra_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        main_cs;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_ok;
  logic        snd_cs;
  logic [14:0] snd_addr;
  logic [7:0]  snd_data;
  logic        snd_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_dst;
  logic [7:0]  sdram_data;

  int pass_n = 0;
  int tot_n  = 0;

  always #5 clk = ~clk;

  jtcontra_rom_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .main_cs    (main_cs),
    .main_addr  (main_addr),
    .main_data  (main_data),
    .main_ok    (main_ok),
    .snd_cs     (snd_cs),
    .snd_addr   (snd_addr),
    .snd_data   (snd_data),
    .snd_ok     (snd_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_data (sdram_data)
  );

  function automatic logic [7:0] mem(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    main_cs    = 1'b0;
    main_addr  = '0;
    snd_cs     = 1'b0;
    snd_addr   = '0;
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b0;
    sdram_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // handshake one request with ack+dst together; addr is X on timeout
  task automatic serve(input logic [7:0] d, output logic [21:0] a);
    bit found;
    wait_req(found);
    a = found ? sdram_addr : 22'hx;
    if (found) begin
      sdram_ack  = 1'b1;
      sdram_dst  = 1'b1;
      sdram_data = d;
      tick();
      sdram_ack  = 1'b0;
      sdram_dst  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_in();
    main_cs = 1'b1;
    snd_cs  = 1'b1;
    tick();
    tick();
    tot_n++;
    if (sdram_req !== 1'b0) $display("FAIL rst_req got %b want 0", sdram_req);
    else pass_n++;
    tot_n++;
    if (sdram_addr !== 22'h0) $display("FAIL rst_addr got %h want 0", sdram_addr);
    else pass_n++;
    tot_n++;
    if (main_ok !== 1'b0 || snd_ok !== 1'b0)
      $display("FAIL rst_ok got %b%b want 00", main_ok, snd_ok);
    else pass_n++;
    tot_n++;
    if (main_data !== 8'h0 || snd_data !== 8'h0)
      $display("FAIL rst_data got %h/%h want 00/00", main_data, snd_data);
    else pass_n++;
    clr_in();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_main_miss();
    int  nreq;
    logic early;
    nreq = 0;
    early = 1'bx;
    main_cs   = 1'b1;
    main_addr = 17'h08000;
    #1;
    tot_n++;
    if (main_ok !== 1'b0) $display("FAIL miss_ok0 got %b want 0", main_ok);
    else pass_n++;
    tick();
    tot_n++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h08000)
      $display("FAIL miss_req got %b/%h want 1/08000", sdram_req, sdram_addr);
    else pass_n++;
    for (int c = 0; c < 8; c++) begin
      if (sdram_req === 1'b1) nreq++;
      if (c == 4) early = main_ok;
      sdram_ack  = (c == 2);
      sdram_dst  = (c == 4);
      sdram_data = (c == 4) ? 8'hA5 : 8'h00;
      tick();
    end
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    tot_n++;
    if (nreq != 3) $display("FAIL miss_req_len got %0d want 3", nreq);
    else pass_n++;
    tot_n++;
    if (early !== 1'b0) $display("FAIL miss_early_ok got %b want 0", early);
    else pass_n++;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'hA5)
      $display("FAIL miss_fill got %b/%h want 1/a5", main_ok, main_data);
    else pass_n++;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 4; i++) begin
      tot_n++;
      if (main_ok !== 1'b1 || main_data !== 8'hA5 || sdram_req !== 1'b0)
        $display("FAIL hit got ok=%b d=%h req=%b want 1/a5/0",
                 main_ok, main_data, sdram_req);
      else pass_n++;
      tick();
    end
    main_cs = 1'b0;
    #1;
    tot_n++;
    if (main_ok !== 1'b0) $display("FAIL hit_cs0 got %b want 0", main_ok);
    else pass_n++;
  endtask

  task automatic test_tie();
    logic [21:0] a;
    do_reset();
    main_cs   = 1'b1;
    main_addr = 17'h01234;
    snd_cs    = 1'b1;
    snd_addr  = 15'h0456;
    serve(8'h11, a);
    tot_n++;
    if (a !== 22'h01234) $display("FAIL tie1 got %h want 01234", a);
    else pass_n++;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'h11 || snd_ok !== 1'b0)
      $display("FAIL tie1_ok got %b/%h/%b want 1/11/0", main_ok, main_data, snd_ok);
    else pass_n++;
    main_addr = 17'h01235;
    serve(8'h22, a);
    tot_n++;
    if (a !== 22'h20456) $display("FAIL tie2 got %h want 20456", a);
    else pass_n++;
    tot_n++;
    if (snd_ok !== 1'b1 || snd_data !== 8'h22)
      $display("FAIL tie2_ok got %b/%h want 1/22", snd_ok, snd_data);
    else pass_n++;
    snd_addr = 15'h7FFF;
    serve(8'h33, a);
    tot_n++;
    if (a !== 22'h01235) $display("FAIL tie3 got %h want 01235", a);
    else pass_n++;
    serve(8'h44, a);
    tot_n++;
    if (a !== 22'h27FFF) $display("FAIL snd_top got %h want 27fff", a);
    else pass_n++;
    tot_n++;
    if (snd_ok !== 1'b1 || snd_data !== 8'h44 || main_data !== 8'h33)
      $display("FAIL tie4_ok got %b/%h/%h want 1/44/33", snd_ok, snd_data, main_data);
    else pass_n++;
  endtask

  task automatic test_addr_change();
    logic [21:0] a;
    bit found;
    main_addr = 17'h00100;
    wait_req(found);
    tot_n++;
    if (!found || sdram_addr !== 22'h00100)
      $display("FAIL chg_req got %b/%h want 1/00100", found, sdram_addr);
    else pass_n++;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    main_addr = 17'h00101;
    tick();
    sdram_dst  = 1'b1;
    sdram_data = 8'h77;
    tick();
    sdram_dst = 1'b0;
    tot_n++;
    if (main_ok !== 1'b0 || snd_ok !== 1'b1)
      $display("FAIL chg_fill got %b/%b want 0/1", main_ok, snd_ok);
    else pass_n++;
    wait_req(found);
    tot_n++;
    if (!found || sdram_addr !== 22'h00101)
      $display("FAIL chg_req2 got %b/%h want 1/00101", found, sdram_addr);
    else pass_n++;
    main_addr = 17'h00100;
    #1;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'h77)
      $display("FAIL chg_tag got %b/%h want 1/77", main_ok, main_data);
    else pass_n++;
    serve(8'h78, a);
    main_addr = 17'h00101;
    #1;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'h78)
      $display("FAIL chg_fill2 got %b/%h want 1/78", main_ok, main_data);
    else pass_n++;
  endtask

  task automatic test_same_cycle();
    logic [21:0] a;
    bit found;
    main_addr = 17'h02000;
    wait_req(found);
    sdram_ack  = 1'b1;
    sdram_dst  = 1'b1;
    sdram_data = 8'h3C;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'h3C || sdram_req !== 1'b0)
      $display("FAIL same_fill got %b/%h/%b want 1/3c/0",
               main_ok, main_data, sdram_req);
    else pass_n++;
    main_addr = 17'h02001;
    tick();
    tot_n++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h02001)
      $display("FAIL same_idle got %b/%h want 1/02001", sdram_req, sdram_addr);
    else pass_n++;
    serve(8'h55, a);
  endtask

  task automatic test_async_reset();
    logic [21:0] a;
    bit found;
    main_addr = 17'h03000;
    wait_req(found);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tot_n++;
    if (sdram_req !== 1'b0 || main_ok !== 1'b0 || snd_ok !== 1'b0)
      $display("FAIL arst got %b/%b/%b want 0/0/0", sdram_req, main_ok, snd_ok);
    else pass_n++;
    @(negedge clk);
    rst_n      = 1'b1;
    sdram_dst  = 1'b1;
    sdram_data = 8'h99;
    tick();
    sdram_dst = 1'b0;
    tot_n++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h03000 || main_ok !== 1'b0)
      $display("FAIL arst_dst got %b/%h/%b want 1/03000/0",
               sdram_req, sdram_addr, main_ok);
    else pass_n++;
    serve(8'hAB, a);
    main_cs = 1'b1;
    #1;
    tot_n++;
    if (main_ok !== 1'b1 || main_data !== 8'hAB)
      $display("FAIL arst_refill got %b/%h want 1/ab", main_ok, main_data);
    else pass_n++;
  endtask

  task automatic test_random();
    logic [16:0] main_pool [4];
    logic [14:0] snd_pool [4];
    bit          m_valid [2];
    logic [16:0] m_tag [2];
    logic [7:0]  m_data [2];
    bit          last_snd, pending, fill_prev, fill_now;
    bit          prev_idle, idle, pm, ps, mm, sm, want_snd;
    logic [16:0] prev_ma;
    logic [14:0] prev_sa;
    logic [21:0] served, want_a;
    logic        exp_ok;
    logic [7:0]  exp_d;
    int          errs;
    main_pool = '{17'h00000, 17'h1FFFF, 17'h08000, 17'h00123};
    snd_pool  = '{15'h0000, 15'h7FFF, 15'h1234, 15'h4000};
    do_reset();
    m_valid   = '{1'b0, 1'b0};
    m_tag     = '{17'h0, 17'h0};
    m_data    = '{8'h0, 8'h0};
    last_snd  = 1'b1;
    pending   = 1'b0;
    fill_prev = 1'b0;
    prev_idle = 1'b0;
    pm = 1'b0; ps = 1'b0;
    prev_ma = '0; prev_sa = '0;
    served = '0;
    errs = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (fill_prev) begin
        if (served >= 22'h20000) begin
          m_valid[1] = 1'b1;
          m_tag[1]   = 17'(served - 22'h20000);
          m_data[1]  = mem(served);
          last_snd   = 1'b1;
        end else begin
          m_valid[0] = 1'b1;
          m_tag[0]   = served[16:0];
          m_data[0]  = mem(served);
          last_snd   = 1'b0;
        end
      end
      if (prev_idle) begin
        want_snd = (pm && ps) ? !last_snd : ps;
        want_a = want_snd ? 22'h20000 + 22'(prev_sa) : 22'(prev_ma);
        tot_n++;
        if (sdram_req !== (pm || ps) ||
            ((pm || ps) && sdram_addr !== want_a)) begin
          $display("FAIL rnd_req cyc %0d got %b/%h want %b/%h",
                   cyc, sdram_req, sdram_addr, pm || ps, want_a);
          errs++;
        end else pass_n++;
      end
      idle = !sdram_req && !pending;
      sdram_ack = 1'b0;
      sdram_dst = 1'b0;
      fill_now  = 1'b0;
      if (sdram_req === 1'b1) begin
        if ($urandom_range(2) == 0) begin
          sdram_ack = 1'b1;
          served    = sdram_addr;
          if ($urandom_range(1) == 0) begin
            sdram_dst = 1'b1;
            fill_now  = 1'b1;
          end else pending = 1'b1;
        end
      end else if (pending) begin
        sdram_ack = ($urandom_range(3) == 0);
        if ($urandom_range(2) == 0) begin
          sdram_dst = 1'b1;
          fill_now  = 1'b1;
          pending   = 1'b0;
        end
      end else begin
        sdram_ack = ($urandom_range(7) == 0);
        sdram_dst = ($urandom_range(7) == 0);
      end
      sdram_data = fill_now ? mem(served) : 8'($urandom);
      if ($urandom_range(7) == 0) main_cs = ~main_cs;
      if ($urandom_range(7) == 0) snd_cs  = ~snd_cs;
      if ($urandom_range(3) == 0) main_addr = main_pool[$urandom_range(3)];
      if ($urandom_range(3) == 0) snd_addr  = snd_pool[$urandom_range(3)];
      #1;
      exp_ok = main_cs && m_valid[0] && (m_tag[0] == main_addr);
      exp_d  = mem(22'(main_addr));
      tot_n++;
      if (main_ok !== exp_ok || (exp_ok && main_data !== exp_d)) begin
        $display("FAIL rnd_main cyc %0d got %b/%h want %b/%h",
                 cyc, main_ok, main_data, exp_ok, exp_d);
        errs++;
      end else pass_n++;
      exp_ok = snd_cs && m_valid[1] && (m_tag[1][14:0] == snd_addr);
      exp_d  = mem(22'h20000 + 22'(snd_addr));
      tot_n++;
      if (snd_ok !== exp_ok || (exp_ok && snd_data !== exp_d)) begin
        $display("FAIL rnd_snd cyc %0d got %b/%h want %b/%h",
                 cyc, snd_ok, snd_data, exp_ok, exp_d);
        errs++;
      end else pass_n++;
      mm = main_cs && !(m_valid[0] && m_tag[0] == main_addr);
      sm = snd_cs && !(m_valid[1] && m_tag[1][14:0] == snd_addr);
      prev_idle = idle;
      pm = mm;
      ps = sm;
      prev_ma = main_addr;
      prev_sa = snd_addr;
      fill_prev = fill_now;
      if (errs > 20) break;
    end
    clr_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    test_reset();
    test_main_miss();
    test_hit();
    test_tie();
    test_addr_change();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
